alu_seq_core: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshake on input and output; successor to the
//  8-bit combinational ALU. Adds SUB/XOR/SHL, carry/zero/neg flags, and an iterative multi-cycle

---
 rtl/alu_pkg.sv | 17 +
 rtl/mul_iter.sv | 63 ++++++
 rtl/alu_seq_core.sv | 151 +++++++++++++++
 tb/tb_alu_seq_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NOTB = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;
endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        // done is combinational: it flags the edge that retires the last multiplier bit
        done     = busy_q && (cnt_q == CW'(WIDTH - 1));
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign prod = acc_d;
endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready handshake; single-cycle ops finish on accept, MUL iterates.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             carry,
    output logic             zero,
    output logic             neg
);
    localparam int SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic               ovf_q, ovf_d, carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
    logic               mul_start, mul_busy, mul_done, ld;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   res_f;
    logic               res_ovf, res_carry;

    generate
        if (MUL_EN) begin : g_mul
            mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk   (clk),
                .rst_n (rst_n),
                .start (mul_start),
                .a     (a),
                .b     (b),
                .busy  (mul_busy),
                .done  (mul_done),
                .prod  (mul_prod)
            );
        end else begin : g_no_mul
            assign mul_busy = 1'b0;
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        res_f     = '0;
        res_ovf   = 1'b0;
        res_carry = 1'b0;
        case (op)
            OP_ADD: begin
                res_f     = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = (a[WIDTH-1] ^ res_f[WIDTH-1]) & (b[WIDTH-1] ^ res_f[WIDTH-1]);
            end
            OP_SUB: begin
                res_f     = diff[WIDTH-1:0];
                res_carry = diff[WIDTH];
                res_ovf   = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ res_f[WIDTH-1]);
            end
            OP_NOTB: res_f = ~b;
            OP_AND:  res_f = a & b;
            OP_OR:   res_f = a | b;
            OP_XOR:  res_f = a ^ b;
            OP_SHL:  res_f = a << b[SHW-1:0];
            // only reaches the result registers when the multiplier is compiled out
            OP_MUL:  res_f = '1;
            default: res_f = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        ovf_d     = ovf_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        mul_start = 1'b0;
        ld        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL && MUL_EN) begin
                        mul_start = 1'b1;
                        state_d   = S_EXEC;
                    end else begin
                        f_d     = res_f;
                        ovf_d   = res_ovf;
                        carry_d = res_carry;
                        ld      = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                if (mul_done) begin
                    f_d     = mul_prod[WIDTH-1:0];
                    ovf_d   = |mul_prod[2*WIDTH-1:WIDTH];
                    carry_d = 1'b0;
                    ld      = 1'b1;
                    state_d = S_DONE;
                end else if (!mul_busy) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // zero/neg follow only freshly loaded results so the reset values stay all-zero
        if (ld) begin
            zero_d = ~|f_d;
            neg_d  = f_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign f         = f_q;
    assign ovf       = ovf_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench: 8-bit core with iterative MUL plus a 16-bit core with MUL compiled out.
module tb_alu_seq_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic [2:0] op = '0;
    logic       in_ready, out_valid, ovf, carry, zero, neg;
    logic [7:0] f;

    logic        in_valid2 = 1'b0;
    logic [15:0] a2 = '0, b2 = '0;
    logic [2:0]  op2 = '0;
    logic        in_ready2, out_valid2, ovf2, carry2, zero2, neg2;
    logic [15:0] f2;

    int n_pass = 0;
    int n_total = 0;

    logic [12:0] obs8;
    logic [20:0] obs16;
    assign obs8  = {out_valid, f, ovf, carry, zero, neg};
    assign obs16 = {out_valid2, f2, ovf2, carry2, zero2, neg2};

    always #5 clk = ~clk;

    alu_seq_core #(.WIDTH(8), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .ovf(ovf), .carry(carry), .zero(zero), .neg(neg)
    );

    alu_seq_core #(.WIDTH(16), .MUL_EN(1'b0)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .op(op2), .out_valid(out_valid2), .out_ready(1'b1),
        .f(f2), .ovf(ovf2), .carry(carry2), .zero(zero2), .neg(neg2)
    );

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [12:0] exp; // {out_valid, f, ovf, carry, zero, neg}
    } vec_t;

    // drives one request for exactly one rising edge; caller sits 1 time unit after an edge
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop);
        a = ia; b = ib; op = iop; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if ({in_ready, obs8} !== {1'b1, 13'h0}) $display("FAIL reset8: got %h exp %h", {in_ready, obs8}, {1'b1, 13'h0});
        else n_pass++;
        n_total++;
        if ({in_ready2, obs16} !== {1'b1, 21'h0}) $display("FAIL reset16: got %h exp %h", {in_ready2, obs16}, {1'b1, 21'h0});
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL idle_after_reset: got %b exp 10", {in_ready, out_valid});
        else n_pass++;
    endtask

    task automatic test_single_cycle_ops();
        vec_t v[12];
        v[0]  = '{"add",      3'b000, 8'h07, 8'h64, {1'b1, 8'h6B, 4'b0000}};
        v[1]  = '{"add_ovf",  3'b000, 8'h50, 8'h5A, {1'b1, 8'hAA, 4'b1001}};
        v[2]  = '{"sub_brw",  3'b100, 8'h00, 8'h01, {1'b1, 8'hFF, 4'b0101}};
        v[3]  = '{"notb",     3'b001, 8'h00, 8'h5A, {1'b1, 8'hA5, 4'b0001}};
        v[4]  = '{"and",      3'b010, 8'h8F, 8'h95, {1'b1, 8'h85, 4'b0001}};
        v[5]  = '{"or",       3'b011, 8'h8F, 8'h95, {1'b1, 8'h9F, 4'b0001}};
        v[6]  = '{"xor",      3'b101, 8'h8F, 8'h95, {1'b1, 8'h1A, 4'b0000}};
        v[7]  = '{"shl3",     3'b110, 8'h81, 8'h03, {1'b1, 8'h08, 4'b0000}};
        v[8]  = '{"shl0",     3'b110, 8'h5C, 8'h08, {1'b1, 8'h5C, 4'b0000}};
        v[9]  = '{"add_wrap", 3'b000, 8'hFF, 8'h01, {1'b1, 8'h00, 4'b0110}};
        v[10] = '{"sub_zero", 3'b100, 8'h05, 8'h05, {1'b1, 8'h00, 4'b0010}};
        v[11] = '{"sub_ovf",  3'b100, 8'h80, 8'h01, {1'b1, 8'h7F, 4'b1000}};
        for (int i = 0; i < 12; i++) begin
            issue(v[i].a, v[i].b, v[i].op);
            n_total++;
            if ({in_ready, obs8} !== {1'b0, v[i].exp})
                $display("FAIL %s: got %h exp %h", v[i].name, {in_ready, obs8}, {1'b0, v[i].exp});
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if ({in_ready, out_valid} !== 2'b10)
                $display("FAIL %s_retire: got %b exp 10", v[i].name, {in_ready, out_valid});
            else n_pass++;
        end
    endtask

    task automatic test_mul();
        logic [7:0]  ma[4];
        logic [7:0]  mb[4];
        logic [12:0] me[4];
        logic        busy_ok;
        ma[0] = 8'd12;  mb[0] = 8'd13;  me[0] = {1'b1, 8'h9C, 4'b0001};
        ma[1] = 8'd16;  mb[1] = 8'd16;  me[1] = {1'b1, 8'h00, 4'b1010};
        ma[2] = 8'hFF;  mb[2] = 8'hFF;  me[2] = {1'b1, 8'h01, 4'b1000};
        ma[3] = 8'h00;  mb[3] = 8'hFF;  me[3] = {1'b1, 8'h00, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            issue(ma[i], mb[i], 3'b111);
            busy_ok = 1'b1;
            // accept edge already taken; 7 more edges still busy, 8th lands in DONE
            for (int k = 1; k < 8; k++) begin
                if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_ok = 1'b0;
                @(posedge clk); #1;
            end
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_ok = 1'b0;
            n_total++;
            if (busy_ok !== 1'b1) $display("FAIL mul%0d_busy: got %b exp 1", i, busy_ok);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if ({in_ready, obs8} !== {1'b0, me[i]})
                $display("FAIL mul%0d: got %h exp %h", i, {in_ready, obs8}, {1'b0, me[i]});
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic hold_ok = 1'b1;
        out_ready = 1'b0;
        issue(8'h07, 8'h64, 3'b000);
        a = 8'hFF; b = 8'hFF; op = 3'b010; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if ({in_ready, obs8} !== {1'b0, 1'b1, 8'h6B, 4'b0000}) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        n_total++;
        if (hold_ok !== 1'b1 || {in_ready, obs8} !== {1'b0, 1'b1, 8'h6B, 4'b0000})
            $display("FAIL bp_hold: got %h exp %h", {in_ready, obs8}, {1'b0, 1'b1, 8'h6B, 4'b0000});
        else n_pass++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release: got %b exp 10", {in_ready, out_valid});
        else n_pass++;
        issue(8'h8F, 8'h95, 3'b101);
        n_total++;
        if (obs8 !== {1'b1, 8'h1A, 4'b0000}) $display("FAIL bp_next: got %h exp %h", obs8, {1'b1, 8'h1A, 4'b0000});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        issue(8'd12, 8'd13, 3'b111);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({in_ready, obs8} !== {1'b1, 13'h0}) $display("FAIL mid_mul_reset: got %h exp %h", {in_ready, obs8}, {1'b1, 13'h0});
        else n_pass++;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL mid_mul_abort: got %b exp 10", {in_ready, out_valid});
        else n_pass++;
        issue(8'h07, 8'h64, 3'b000);
        n_total++;
        if (obs8 !== {1'b1, 8'h6B, 4'b0000}) $display("FAIL post_reset_add: got %h exp %h", obs8, {1'b1, 8'h6B, 4'b0000});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_disabled();
        a2 = 16'h1234; b2 = 16'h0002; op2 = 3'b111; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n_total++;
        if (obs16 !== {1'b1, 16'hFFFF, 4'b0001}) $display("FAIL mul_off: got %h exp %h", obs16, {1'b1, 16'hFFFF, 4'b0001});
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({in_ready2, out_valid2} !== 2'b10) $display("FAIL mul_off_retire: got %b exp 10", {in_ready2, out_valid2});
        else n_pass++;
        a2 = 16'h7FFF; b2 = 16'h0001; op2 = 3'b000; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n_total++;
        if (obs16 !== {1'b1, 16'h8000, 4'b1001}) $display("FAIL add16_ovf: got %h exp %h", obs16, {1'b1, 16'h8000, 4'b1001});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_cycle_ops();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_mul_disabled();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
